// File: rtl/imm_decode_stage.sv
// imm_decode_stage
//   Registered immediate-decode stage between fetch and execute. Each accepted
//   instruction is classified (R/I/S/B/U/J/ILL), its immediate is sign-extended
//   to XLEN, and instr/pc are forwarded one cycle later. A 2-entry skid buffer
//   (out stage + skid register) keeps in_ready free of any combinational path
//   from out_ready.
//
//   Optional feature macro: IMM_TARGET_EN
//     defined     -> out_target port exists; carries pc+imm registered with the entry
//     not defined -> no out_target port and no adder
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   flush                synchronous discard of all buffered entries
//   cnt_clr              synchronous clear of ill_cnt
//   in_valid/in_ready    upstream handshake
//   in_instr, in_pc      instruction word and its address
//   out_valid/out_ready  downstream handshake
//   out_instr, out_pc    forwarded instruction and address
//   out_fmt              R=0 I=1 S=2 B=3 U=4 J=5 ILL=7
//   out_imm              sign-extended immediate (shamt zero-extended)
//   out_target           pc+imm (IMM_TARGET_EN only)
//   ill_cnt              saturating count of accepted ILL entries

module imm_decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             cnt_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_imm,
`ifdef IMM_TARGET_EN
    output logic [XLEN-1:0]  out_target,
`endif
    output logic [CNT_W-1:0] ill_cnt
);

    typedef enum logic [2:0] {
        FmtR   = 3'd0,
        FmtI   = 3'd1,
        FmtS   = 3'd2,
        FmtB   = 3'd3,
        FmtU   = 3'd4,
        FmtJ   = 3'd5,
        FmtIll = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
`ifdef IMM_TARGET_EN
        logic [XLEN-1:0] target;
`endif
    } entry_t;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpOp     = 7'b0110011;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t           r_out;
    entry_t           r_skid;
    logic             r_out_valid;
    logic             r_skid_valid;
    logic [CNT_W-1:0] r_ill_cnt;

    entry_t           w_out_nxt;
    entry_t           w_skid_nxt;
    logic             w_out_valid_nxt;
    logic             w_skid_valid_nxt;
    logic [CNT_W-1:0] w_ill_cnt_nxt;

    // ------------------------------------------------------------------
    // Decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    fmt_e            w_fmt;
    logic            w_is_shift;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    entry_t          w_in_entry;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];

    always_comb begin
        w_fmt = FmtIll;
        if (in_instr[1:0] == 2'b11) begin
            case (w_opcode)
                OpLui, OpAuipc:                                w_fmt = FmtU;
                OpJal:                                         w_fmt = FmtJ;
                OpJalr, OpLoad, OpOpImm, OpFence, OpSystem:    w_fmt = FmtI;
                OpStore:                                       w_fmt = FmtS;
                OpBranch:                                      w_fmt = FmtB;
                OpOp:                                          w_fmt = FmtR;
                default:                                       w_fmt = FmtIll;
            endcase
        end
    end

    assign w_is_shift = (w_fmt == FmtI) && (w_opcode == OpOpImm) &&
                        ((w_funct3 == 3'b001) || (w_funct3 == 3'b101));

    // Immediates are assembled as 32-bit signed values and then widened to XLEN;
    // a shamt always has bit 31 clear, so the same widening zero-extends it.
    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            FmtI: begin
                if (w_is_shift) begin
                    if (XLEN == 64) begin
                        w_imm32 = {26'b0, in_instr[25:20]};
                    end else begin
                        w_imm32 = {27'b0, in_instr[24:20]};
                    end
                end else begin
                    w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            FmtS: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FmtB: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            FmtU: w_imm32 = {in_instr[31:12], 12'b0};
            FmtJ: w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign w_imm = XLEN'($signed(w_imm32));

    always_comb begin
        w_in_entry        = '0;
        w_in_entry.instr  = in_instr;
        w_in_entry.pc     = in_pc;
        w_in_entry.fmt    = w_fmt;
        w_in_entry.imm    = w_imm;
`ifdef IMM_TARGET_EN
        w_in_entry.target = in_pc + w_imm;
`endif
    end

    // ------------------------------------------------------------------
    // Handshake and skid buffer
    // ------------------------------------------------------------------
    logic w_in_fire;
    logic w_out_fire;

    // Input presented during a flush is dropped outright.
    assign w_in_fire  = in_valid && !r_skid_valid && !flush;
    assign w_out_fire = r_out_valid && out_ready;

    always_comb begin
        w_out_nxt        = r_out;
        w_skid_nxt       = r_skid;
        w_out_valid_nxt  = r_out_valid;
        w_skid_valid_nxt = r_skid_valid;

        if (flush) begin
            w_out_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (r_skid_valid) begin
            // in_ready is low here, so only the skid-to-out move can happen.
            if (w_out_fire) begin
                w_out_nxt        = r_skid;
                w_skid_valid_nxt = 1'b0;
            end
        end else if (w_in_fire) begin
            if (!r_out_valid || out_ready) begin
                w_out_nxt       = w_in_entry;
                w_out_valid_nxt = 1'b1;
            end else begin
                w_skid_nxt       = w_in_entry;
                w_skid_valid_nxt = 1'b1;
            end
        end else if (w_out_fire) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Illegal-instruction counter: clear wins over increment, saturates at max
    // ------------------------------------------------------------------
    always_comb begin
        w_ill_cnt_nxt = r_ill_cnt;
        if (cnt_clr) begin
            w_ill_cnt_nxt = '0;
        end else if (w_in_fire && (w_fmt == FmtIll) && !(&r_ill_cnt)) begin
            w_ill_cnt_nxt = r_ill_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ill_cnt    <= '0;
        end else begin
            r_out        <= w_out_nxt;
            r_skid       <= w_skid_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_ill_cnt    <= w_ill_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready   = !r_skid_valid;
    assign out_valid  = r_out_valid;
    assign out_instr  = r_out.instr;
    assign out_pc     = r_out.pc;
    assign out_fmt    = r_out.fmt;
    assign out_imm    = r_out.imm;
`ifdef IMM_TARGET_EN
    assign out_target = r_out.target;
`endif
    assign ill_cnt    = r_ill_cnt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage
//   Directed-vector bench for imm_decode_stage (XLEN=32, CNT_W=8). Inputs are
//   driven 1 time unit after the rising edge and outputs sampled at the same
//   point, so every sample sees settled register outputs.

module tb_imm_decode_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             cnt_clr;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [XLEN-1:0]  out_pc;
    logic [2:0]       out_fmt;
    logic [XLEN-1:0]  out_imm;
`ifdef IMM_TARGET_EN
    logic [XLEN-1:0]  out_target;
`endif
    logic [CNT_W-1:0] ill_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_fmt    (out_fmt),
        .out_imm    (out_imm),
`ifdef IMM_TARGET_EN
        .out_target (out_target),
`endif
        .ill_cnt    (ill_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated transfer with out_ready=1; checks the decoded result.
    task automatic send_chk(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic [2:0] fmt, input logic [31:0] imm);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
        check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
        check_val({tag, "_fmt"},   64'(out_fmt),   64'(fmt));
        check_val({tag, "_imm"},   64'(out_imm),   64'(imm));
        check_val({tag, "_instr"}, 64'(out_instr), 64'(instr));
        check_val({tag, "_pc"},    64'(out_pc),    64'(pc));
        step();
    endtask

    initial begin
        logic [CNT_W-1:0] cnt_snap;

        rst_n     = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        #3;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_in_ready",  64'(in_ready),  64'd1);
        check_val("rst_ill_cnt",   64'(ill_cnt),   64'd0);
        check_val("rst_out_imm",   64'(out_imm),   64'd0);
        check_val("rst_out_instr", 64'(out_instr), 64'd0);
        check_val("rst_out_fmt",   64'(out_fmt),   64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Format and immediate vectors
        send_chk("addi",  32'h00500113, 32'h0000_0000, 3'd1, 32'h0000_0005);
        send_chk("sw",    32'hFE112E23, 32'h0000_0004, 3'd2, 32'hFFFF_FFFC);
        in_valid = 1'b1;
        in_instr = 32'h00208463;
        in_pc    = 32'h0000_0100;
        step();
        in_valid = 1'b0;
        check_val("beq_fmt", 64'(out_fmt), 64'd3);
        check_val("beq_imm", 64'(out_imm), 64'h8);
`ifdef IMM_TARGET_EN
        check_val("beq_target", 64'(out_target), 64'h108);
`endif
        step();
        send_chk("lui",   32'h12345137, 32'h0000_0010, 3'd4, 32'h1234_5000);
        send_chk("luineg",32'h80000037, 32'h0000_0014, 3'd4, 32'h8000_0000);
        send_chk("jal",   32'h004000EF, 32'h0000_0018, 3'd5, 32'h0000_0004);
        send_chk("addim1",32'hFFF00093, 32'h0000_001C, 3'd1, 32'hFFFF_FFFF);
        send_chk("srai",  32'h41F0D093, 32'h0000_0020, 3'd1, 32'h0000_001F);
        send_chk("add",   32'h002081B3, 32'h0000_0024, 3'd0, 32'h0000_0000);
        send_chk("ill0",  32'h00000000, 32'h0000_0028, 3'd7, 32'h0000_0000);
        check_val("ill_cnt_1", 64'(ill_cnt), 64'd1);
        send_chk("rvc",   32'hFFFFF001, 32'h0000_002C, 3'd7, 32'h0000_0000);
        send_chk("badop", 32'h0000007F, 32'h0000_0030, 3'd7, 32'h0000_0000);
        check_val("ill_cnt_3", 64'(ill_cnt), 64'd3);
        check_val("idle_valid", 64'(out_valid), 64'd0);

        // Backpressure: A to out stage, B to skid, C refused
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        step();
        in_instr  = 32'h00200093;
        step();
        check_val("bp_in_ready_0", 64'(in_ready), 64'd0);
        in_instr  = 32'h00300093;
        step();
        check_val("bp_hold_valid", 64'(out_valid), 64'd1);
        check_val("bp_hold_instr", 64'(out_instr), 64'h00100093);
        check_val("bp_hold_ready", 64'(in_ready),  64'd0);
        out_ready = 1'b1;
        step();
        check_val("bp_second",     64'(out_instr), 64'h00200093);
        check_val("bp_second_imm", 64'(out_imm),   64'h2);
        check_val("bp_ready_back", 64'(in_ready),  64'd1);
        step();
        check_val("bp_third",      64'(out_instr), 64'h00300093);
        in_valid = 1'b0;
        step();
        check_val("bp_drained",    64'(out_valid), 64'd0);

        // Flush with both entries full
        cnt_snap  = ill_cnt;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00400093;
        step();
        in_instr  = 32'h00500093;
        step();
        check_val("fl_full", 64'(in_ready), 64'd0);
        flush    = 1'b1;
        in_instr = 32'h00000000;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("fl_out_valid", 64'(out_valid), 64'd0);
        check_val("fl_in_ready",  64'(in_ready),  64'd1);
        check_val("fl_ill_cnt",   64'(ill_cnt),   64'(cnt_snap));

        // ILL input presented during flush into an empty stage is dropped
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00000000;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("fl_drop_valid", 64'(out_valid), 64'd0);
        check_val("fl_drop_cnt",   64'(ill_cnt),   64'd3);
        out_ready = 1'b1;

        // cnt_clr coinciding with an accepted ILL entry gives 0
        cnt_clr  = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00000000;
        step();
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
        check_val("clr_ill_cnt", 64'(ill_cnt), 64'd0);
        check_val("clr_entry",   64'(out_valid), 64'd1);
        step();

        // Saturation: 260 back-to-back ILL entries
        in_valid = 1'b1;
        in_instr = 32'h00000000;
        for (int i = 0; i < 260; i++) begin
            step();
        end
        in_valid = 1'b0;
        check_val("sat_ill_cnt", 64'(ill_cnt), 64'hFF);
        step();

        // Asynchronous reset with a held entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00600093;
        step();
        in_instr  = 32'h00700093;
        step();
        in_valid  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", 64'(out_valid), 64'd0);
        check_val("arst_in_ready",  64'(in_ready),  64'd1);
        check_val("arst_ill_cnt",   64'(ill_cnt),   64'd0);
        check_val("arst_out_instr", 64'(out_instr), 64'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        check_val("arst_after", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
